// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// Each stage resolves GRP carry-select blocks; the carry between stages is registered.
module csel_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4,
    parameter int GRP   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLOCK;
    localparam int LAT  = NBLK / GRP;
    localparam int GW   = GRP * BLOCK;

    // Returns {carry_out, sum} for one stage's worth of carry-select blocks.
    function automatic logic [GW:0] groupAdd(input logic [GW-1:0] x,
                                             input logic [GW-1:0] y,
                                             input logic          ci);
        logic [GW-1:0]    s;
        logic [BLOCK-1:0] s0;
        logic [BLOCK-1:0] s1;
        logic             c;
        logic             r0;
        logic             r1;
        logic             p;
        logic             g;
        s = '0;
        c = ci;
        for (int k = 0; k < GRP; k++) begin
            s0 = '0;
            s1 = '0;
            r0 = 1'b0;
            r1 = 1'b1;
            for (int j = 0; j < BLOCK; j++) begin
                p     = x[k*BLOCK+j] ^ y[k*BLOCK+j];
                g     = x[k*BLOCK+j] & y[k*BLOCK+j];
                s0[j] = p ^ r0;
                s1[j] = p ^ r1;
                r0    = g | (p & r0);
                r1    = g | (p & r1);
            end
            s[k*BLOCK +: BLOCK] = c ? s1 : s0;
            c = c ? r1 : r0;
        end
        return {c, s};
    endfunction

    logic [LAT-1:0]   valid_q;
    logic [LAT-1:0]   valid_d;
    logic [LAT-1:0]   carry_q;
    logic [LAT-1:0]   carry_d;
    logic [WIDTH-1:0] opA_q  [LAT];
    logic [WIDTH-1:0] opA_d  [LAT];
    logic [WIDTH-1:0] opB_q  [LAT];
    logic [WIDTH-1:0] opB_d  [LAT];
    logic [WIDTH-1:0] pSum_q [LAT];
    logic [WIDTH-1:0] pSum_d [LAT];

    logic             outValid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             ovf_d;
    logic             stall;

    assign stall    = outValid_q & ~out_ready;
    assign in_ready = ~stall;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        logic [WIDTH-1:0] srcA;
        logic [WIDTH-1:0] srcB;
        logic [WIDTH-1:0] srcSum;
        logic             srcC;
        logic             srcV;
        logic [GW:0]      grp;
        logic [WIDTH-1:0] merged;

        if (s == 0) begin : g_first
            assign srcA   = a;
            assign srcB   = sub ? ~b : b;
            assign srcC   = sub ? ~cin : cin;
            assign srcSum = '0;
            assign srcV   = in_valid;
        end else begin : g_next
            assign srcA   = opA_q[s-1];
            assign srcB   = opB_q[s-1];
            assign srcC   = carry_q[s-1];
            assign srcSum = pSum_q[s-1];
            assign srcV   = valid_q[s-1];
        end

        assign grp = groupAdd(srcA[s*GW +: GW], srcB[s*GW +: GW], srcC);

        always_comb begin
            merged = srcSum;
            merged[s*GW +: GW] = grp[GW-1:0];
        end

        assign valid_d[s] = srcV;
        assign carry_d[s] = grp[GW];
        assign opA_d[s]   = srcA;
        assign opB_d[s]   = srcB;
        assign pSum_d[s]  = merged;
    end

    // Operands with equal signs whose result sign differs is exactly carry-in(MSB) ^ carry-out(MSB).
    assign ovf_d = (opA_q[LAT-1][WIDTH-1] == opB_q[LAT-1][WIDTH-1]) &
                   (pSum_q[LAT-1][WIDTH-1] != opA_q[LAT-1][WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            carry_q    <= '0;
            for (int s = 0; s < LAT; s++) begin
                opA_q[s]  <= '0;
                opB_q[s]  <= '0;
                pSum_q[s] <= '0;
            end
            outValid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (!stall) begin
            valid_q    <= valid_d;
            carry_q    <= carry_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            pSum_q     <= pSum_d;
            outValid_q <= valid_q[LAT-1];
            sum_q      <= pSum_q[LAT-1];
            cout_q     <= carry_q[LAT-1];
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid = outValid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe: directed literal cases plus a random scoreboard run
// on the default 32-bit build and a 16-bit/2-bit-block/4-block-group build.
module tb_csel_adder_pipe;

    logic        clk;
    logic        rst_n;

    logic        inValidA, inReadyA, cinA, subA, outValidA, outReadyA, coutA, ovfA;
    logic [31:0] aA, bA, sumA;
    logic        inValidB, inReadyB, cinB, subB, outValidB, outReadyB, coutB, ovfB;
    logic [15:0] aB, bB, sumB;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } expT;

    expT qA[$];
    expT qB[$];
    int  checks = 0;
    int  errors = 0;
    int  popsA  = 0;

    csel_adder_pipe dutA (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValidA), .in_ready(inReadyA),
        .a(aA), .b(bA), .cin(cinA), .sub(subA),
        .out_valid(outValidA), .out_ready(outReadyA),
        .sum(sumA), .cout(coutA), .ovf(ovfA)
    );

    csel_adder_pipe #(.WIDTH(16), .BLOCK(2), .GRP(4)) dutB (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValidB), .in_ready(inReadyB),
        .a(aB), .b(bB), .cin(cinB), .sub(subB),
        .out_valid(outValidB), .out_ready(outReadyB),
        .sum(sumB), .cout(coutB), .ovf(ovfB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Golden model: plain signed/unsigned integer arithmetic on the raw operands.
    function automatic expT refModel(input int w, input logic [63:0] x, input logic [63:0] y,
                                     input logic ci, input logic sb);
        expT    r;
        longint one;
        longint sx, sy, res, full;
        one = 1;
        sx  = x[w-1] ? longint'(x) - (one << w) : longint'(x);
        sy  = y[w-1] ? longint'(y) - (one << w) : longint'(y);
        if (sb) begin
            full   = longint'(x) - longint'(y) - longint'(ci);
            res    = sx - sy - longint'(ci);
            r.cout = (full >= 0);
        end else begin
            full   = longint'(x) + longint'(y) + longint'(ci);
            res    = sx + sy + longint'(ci);
            r.cout = (full >= (one << w));
        end
        r.sum = 64'(full) & ((64'd1 << w) - 64'd1);
        r.ovf = (res >= (one << (w - 1))) || (res < -(one << (w - 1)));
        return r;
    endfunction

    function automatic logic [31:0] randOp32();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: every valid output is compared against the oldest outstanding beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            qA.delete();
            qB.delete();
        end else begin
            if (outValidA) begin
                if (qA.size() == 0) begin
                    chk("A spurious out_valid", 64'(outValidA), 64'd0);
                end else begin
                    chk("A sum", 64'(sumA), qA[0].sum);
                    chk("A cout", 64'(coutA), 64'(qA[0].cout));
                    chk("A ovf", 64'(ovfA), 64'(qA[0].ovf));
                    if (outReadyA) begin
                        qA.delete(0);
                        popsA++;
                    end
                end
            end
            chk("A in_ready", 64'(inReadyA), 64'(!(outValidA && !outReadyA)));
            if (inValidA && inReadyA) qA.push_back(refModel(32, 64'(aA), 64'(bA), cinA, subA));

            if (outValidB) begin
                if (qB.size() == 0) begin
                    chk("B spurious out_valid", 64'(outValidB), 64'd0);
                end else begin
                    chk("B sum", 64'(sumB), qB[0].sum);
                    chk("B cout", 64'(coutB), 64'(qB[0].cout));
                    chk("B ovf", 64'(ovfB), 64'(qB[0].ovf));
                    if (outReadyB) qB.delete(0);
                end
            end
            chk("B in_ready", 64'(inReadyB), 64'(!(outValidB && !outReadyB)));
            if (inValidB && inReadyB) qB.push_back(refModel(16, 64'(aB), 64'(bB), cinB, subB));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic sb);
        int tries;
        bit acc;
        aA = x; bA = y; cinA = ci; subA = sb; inValidA = 1'b1;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 50) begin
            @(negedge clk);
            acc = inReadyA;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!acc) chk("handshake timeout", 64'(inReadyA), 64'd1);
        inValidA = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] es,
                               input logic ec, input logic eo);
        int n;
        n = 0;
        while (!outValidA && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'd4);
        chk({name, " sum"}, 64'(sumA), 64'(es));
        chk({name, " cout"}, 64'(coutA), 64'(ec));
        chk({name, " ovf"}, 64'(ovfA), 64'(eo));
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  start, n, cnt, sentA, sentB, guard;
        bit  accA, accB;
        bit  ov[12];
        localparam int N = 10000;

        rst_n = 1'b0;
        inValidA = 0; aA = 0; bA = 0; cinA = 0; subA = 0; outReadyA = 1;
        inValidB = 0; aB = 0; bB = 0; cinB = 0; subB = 0; outReadyB = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset out_valid", 64'(outValidA), 64'd0);
        chk("reset sum", 64'(sumA), 64'd0);
        chk("reset cout", 64'(coutA), 64'd0);
        chk("reset ovf", 64'(ovfA), 64'd0);
        chk("reset in_ready", 64'(inReadyA), 64'd1);
        chk("reset B out_valid", 64'(outValidB), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] directed add/sub cases");
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        checkOutput("add wrap", 32'h0000_0000, 1'b1, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        checkOutput("add ovf cin", 32'h8000_0000, 1'b0, 1'b1);
        applyStimulus(32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        checkOutput("carry chain", 32'h1000_0000, 1'b0, 1'b0);
        applyStimulus(32'd5, 32'd7, 1'b0, 1'b1);
        checkOutput("sub borrow", 32'hFFFF_FFFE, 1'b0, 1'b0);
        applyStimulus(32'd5, 32'd3, 1'b1, 1'b1);
        checkOutput("sub borrow-in", 32'h0000_0001, 1'b1, 1'b0);
        applyStimulus(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        checkOutput("sub ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);
        repeat (8) @(posedge clk);
        #1;

        $display("[TB] streaming with backpressure");
        start = popsA;
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(32'(i), 32'(i) << 28, 1'b0, 1'b0);
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    outReadyA = !(c >= 6 && c <= 9);
                    @(negedge clk);
                    if (c >= 6 && c <= 9) chk("stall in_ready", 64'(inReadyA), 64'd0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        outReadyA = 1'b1;
        n = 0;
        while ((popsA - start) < 8 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stream result count", 64'(popsA - start), 64'd8);
        chk("stream queue empty", 64'(qA.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] bubble pattern");
        for (int c = 0; c < 12; c++) begin
            inValidA = (c < 4) && (c % 2 == 0);
            aA = 32'(c); bA = 32'(c * 3); cinA = 0; subA = 0;
            @(negedge clk);
            ov[c] = outValidA;
            @(posedge clk);
            #1;
        end
        inValidA = 1'b0;
        for (int c = 0; c < 12; c++)
            chk($sformatf("bubble out_valid[%0d]", c), 64'(ov[c]),
                64'((c >= 5) && (c < 9) && ((c - 5) % 2 == 0)));
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] reset while results are pending");
        outReadyA = 1'b0;
        applyStimulus(32'd1, 32'd2, 1'b0, 1'b0);
        n = 0;
        while (!outValidA && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("held result before reset", 64'(outValidA), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 64'(outValidA), 64'd0);
        chk("async reset sum", 64'(sumA), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        outReadyA = 1'b1;
        applyStimulus(32'd10, 32'd20, 1'b0, 1'b0);
        applyStimulus(32'd30, 32'd40, 1'b0, 1'b0);
        applyStimulus(32'd50, 32'd60, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-flight reset out_valid", 64'(outValidA), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (outValidA) cnt++;
        end
        chk("no stale result after reset", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] random scoreboard run on both builds");
        sentA = 0; sentB = 0; guard = 0; accA = 0; accB = 0;
        while ((sentA < N || sentB < N) && guard < 200000) begin
            @(posedge clk);
            #1;
            if (!inValidA || accA) begin
                if (sentA < N) begin
                    inValidA = ($urandom_range(0, 3) != 0);
                    aA = randOp32(); bA = randOp32();
                    cinA = 1'($urandom); subA = 1'($urandom);
                end else begin
                    inValidA = 1'b0;
                end
            end
            if (!inValidB || accB) begin
                if (sentB < N) begin
                    inValidB = ($urandom_range(0, 3) != 0);
                    aB = 16'($urandom); bB = 16'($urandom);
                    cinB = 1'($urandom); subB = 1'($urandom);
                end else begin
                    inValidB = 1'b0;
                end
            end
            outReadyA = ($urandom_range(0, 3) != 0);
            outReadyB = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            accA = inValidA && inReadyA;
            accB = inValidB && inReadyB;
            if (accA) sentA++;
            if (accB) sentB++;
            guard++;
        end
        chk("random A beats issued", 64'(sentA), 64'(N));
        chk("random B beats issued", 64'(sentB), 64'(N));
        @(posedge clk);
        #1;
        inValidA = 1'b0; inValidB = 1'b0;
        outReadyA = 1'b1; outReadyB = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("random A all drained", 64'(qA.size()), 64'd0);
        chk("random B all drained", 64'(qB.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
